// File: rtl/vdma_rd_pkg.sv
// vdma_rd_pkg: shared definitions for the VDMA read-side prefetch buffer.
//   state_t    : controller states (IDLE, FLUSH, RUN)
//   REQ_LEN_W  : width of the read-request length field
//   clog2()    : ceiling log2 for elaboration-time sizing
package vdma_rd_pkg;

    localparam int unsigned REQ_LEN_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RUN
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vdma_sdp_ram.sv
// vdma_sdp_ram: simple dual-port RAM, DEPTH x DSIZE, registered read.
//   clock, rst_n : clock and asynchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates the cycle after re
// A read of an address written in the same cycle returns the old contents.
module vdma_sdp_ram
    import vdma_rd_pkg::*;
#(
    parameter  int unsigned DSIZE = 24,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vdma_rd_prefetch_buf.sv
// vdma_rd_prefetch_buf: read-side prefetch buffer of the VDMA output path.
// Issues burst read requests bounded by buffer credits, stores returned
// beats and presents them first-word-fall-through. Flushed on frame_start.
//   clock, rst_n          : clock, asynchronous active-low reset
//   enable                : low inhibits new requests
//   frame_start           : flush and start a frame of hactive*vactive beats
//   req_valid/ready/len   : burst read request to the memory read master
//   din, din_valid        : returned beats (always accepted)
//   in_data, fifo_empty,
//   rd_en                 : FWFT read interface
//   underrun_cnt          : rd_en-while-empty counter, built only when
//                           VDMA_RD_UNDERRUN_CNT_EN is defined (else 0)
module vdma_rd_prefetch_buf
    import vdma_rd_pkg::*;
#(
    parameter int unsigned DSIZE     = 24,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BURST_LEN = 64
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic [15:0]          hactive,
    input  logic [15:0]          vactive,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [REQ_LEN_W-1:0] req_len,
    input  logic [DSIZE-1:0]     din,
    input  logic                 din_valid,
    output logic [DSIZE-1:0]     in_data,
    output logic                 fifo_empty,
    input  logic                 rd_en,
    output logic [15:0]          underrun_cnt
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        pending_q, pending_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [31:0]          remaining_q, remaining_d;
    logic                 req_valid_q, req_valid_d;
    logic [REQ_LEN_W-1:0] req_len_q, req_len_d;
    logic                 byp_sel_q;
    logic [DSIZE-1:0]     byp_data_q;
    logic [DSIZE-1:0]     ram_rdata;

    logic        accept;
    logic        beat_take;
    logic        wr_en;
    logic        pop;
    logic        byp_hit;
    logic [31:0] room_d;

    assign fifo_empty = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        accept      = req_valid_q & req_ready;
        beat_take   = din_valid & (pending_q != '0);
        wr_en       = beat_take & (state_q == RUN) & ~frame_start;
        pop         = rd_en & ~fifo_empty;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        req_valid_d = 1'b0;
        req_len_d   = req_len_q;

        case (state_q)
            IDLE:    if (frame_start) state_d = FLUSH;
            FLUSH:   if (!frame_start && pending_q == '0) state_d = RUN;
            RUN:     if (frame_start) state_d = FLUSH;
            default: state_d = IDLE;
        endcase

        // An accepted request always credits pending, even on frame_start:
        // its beats will still return and must be discarded during FLUSH.
        pending_d = pending_q + (accept ? CW'(req_len_q) : '0) - CW'(beat_take);

        if (frame_start) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            remaining_d = 32'(hactive) * 32'(vactive);
        end else begin
            count_d  = count_q + CW'(wr_en) - CW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(wr_en);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            if (accept) begin
                remaining_d = remaining_q - 32'(req_len_q);
            end
        end

        room_d = 32'(DEPTH) - 32'(count_d) - 32'(pending_d);

        // The request register is evaluated on next-cycle values so that
        // req_valid reflects the credit rule in the cycle it is presented.
        if (req_valid_q && !req_ready && !frame_start) begin
            req_valid_d = 1'b1;
        end else begin
            req_valid_d = (state_d == RUN) && enable && (remaining_d != '0) &&
                          (room_d >= BURST_LEN);
            req_len_d   = (remaining_d < BURST_LEN) ? remaining_d[REQ_LEN_W-1:0]
                                                    : REQ_LEN_W'(BURST_LEN);
        end

        // The RAM read is registered, so a beat written to the entry that
        // becomes head next cycle is forwarded through the bypass register.
        byp_hit = wr_en && (wr_ptr_q == rd_ptr_d);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pending_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            req_valid_q <= 1'b0;
            req_len_q   <= '0;
            byp_sel_q   <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            req_valid_q <= req_valid_d;
            req_len_q   <= req_len_d;
            byp_sel_q   <= byp_hit;
            if (byp_hit) begin
                byp_data_q <= din;
            end
        end
    end

    vdma_sdp_ram #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (1'b1),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    assign in_data   = fifo_empty ? '0 : (byp_sel_q ? byp_data_q : ram_rdata);
    assign req_valid = req_valid_q;
    assign req_len   = req_len_q;

`ifdef VDMA_RD_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= '0;
        end else if (frame_start) begin
            underrun_q <= '0;
        end else if ((state_q == RUN) && rd_en && fifo_empty && (underrun_q != '1)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vdma_rd_prefetch_buf.sv
module tb_vdma_rd_prefetch_buf;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic [15:0] hactive;
    logic [15:0] vactive;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_len;
    logic [23:0] din;
    logic        din_valid;
    logic [23:0] in_data;
    logic        fifo_empty;
    logic        rd_en;
    logic [15:0] underrun_cnt;

    always #5 clock = ~clock;

    vdma_rd_prefetch_buf #(
        .DSIZE     (24),
        .DEPTH     (1024),
        .BURST_LEN (64)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_start  (frame_start),
        .hactive      (hactive),
        .vactive      (vactive),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_len      (req_len),
        .din          (din),
        .din_valid    (din_valid),
        .in_data      (in_data),
        .fifo_empty   (fifo_empty),
        .rd_en        (rd_en),
        .underrun_cnt (underrun_cnt)
    );

    typedef struct {
        int          tag;
        logic [23:0] data;
        int          rdy;
    } beat_t;

    typedef struct {
        int h;
        int v;
        int en_pct;
        int exp_reqs;
        int exp_last;
    } vec_t;

    // Reference model: memory master in-flight beats tagged by frame, and
    // the expected buffer contents as a plain queue.
    beat_t       flight[$];
    logic [23:0] mq[$];
    int          m_pend, m_old, frame_no, seq, reads, n_req, last_len, cyc, coin;
    int unsigned m_rem;
    int          cur_btag;
    int          lat = 3, din_pct = 80, rdy_pct = 70, rd_pct = 60, en_pct = 100;
    bit          rd_auto = 1'b1;
    bit          prev_hold, prev_fs;
    logic [8:0]  prev_len;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cycle();
        bit          acc, pop, beat, fs;
        int          len, btag;
        logic [23:0] bdata;
        int unsigned frame_beats;

        chk("fifo_empty", fifo_empty, mq.size() == 0);
        if (mq.size() != 0) chk("in_data", in_data, mq[0]);
        if (prev_hold) begin
            chk("req_hold_valid", req_valid, 1);
            chk("req_hold_len", req_len, prev_len);
        end
        if (prev_fs) chk("req_drop_on_fs", req_valid, 0);
        if (req_valid === 1'b1) begin
            chk("req_room", (1024 - mq.size() - m_pend) >= 64, 1);
            chk("req_remaining", m_rem != 0, 1);
            chk("req_len", req_len, (m_rem < 64) ? m_rem : 32'd64);
            chk("req_after_flush", m_old == 0, 1);
        end

        acc         = req_valid && req_ready;
        len         = int'(req_len);
        pop         = rd_en && (mq.size() != 0);
        beat        = din_valid;
        btag        = cur_btag;
        bdata       = din;
        fs          = frame_start;
        frame_beats = int'(hactive) * int'(vactive);
        prev_hold   = req_valid && !req_ready && !frame_start;
        prev_len    = req_len;
        prev_fs     = fs;
        if (acc && beat && pop) coin++;

        @(posedge clock);
        #1;
        cyc++;

        if (acc) begin
            for (int k = 0; k < len; k++) begin
                flight.push_back('{tag: frame_no,
                                   data: 24'(((frame_no & 255) << 16) | (seq & 16'hFFFF)),
                                   rdy: cyc + lat});
                seq++;
            end
            m_pend += len;
            m_rem  -= len;
            n_req++;
            last_len = len;
        end
        if (pop) begin
            void'(mq.pop_front());
            reads++;
        end
        if (beat) begin
            if (m_pend > 0) m_pend--;
            if (btag != frame_no) m_old--;
            else if (!fs) mq.push_back(bdata);
        end
        if (fs) begin
            frame_no++;
            seq      = 0;
            reads    = 0;
            n_req    = 0;
            last_len = 0;
            mq.delete();
            m_old = m_pend;
            m_rem = frame_beats;
        end

        if (flight.size() != 0 && flight[0].rdy <= cyc && $urandom_range(99) < din_pct) begin
            din_valid = 1'b1;
            din       = flight[0].data;
            cur_btag  = flight[0].tag;
            void'(flight.pop_front());
        end else begin
            din_valid = 1'b0;
            din       = 24'($urandom);
        end
        req_ready = ($urandom_range(99) < rdy_pct);
        enable    = ($urandom_range(99) < en_pct);
        if (rd_auto) rd_en = ($urandom_range(99) < rd_pct);
    endtask

    task automatic frame_begin(input int h, input int v);
        hactive     = 16'(h);
        vactive     = 16'(v);
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic finish_frame(input int exp_reqs, input int exp_last, input int bound);
        int unsigned total;
        bit          done;
        total = int'(hactive) * int'(vactive);
        done  = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (reads == int'(total) && flight.size() == 0 && m_rem == 0 && m_pend == 0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        chk("frame_done", done, 1);
        repeat (20) cycle();
        chk("frame_n_req", n_req, exp_reqs);
        chk("frame_last_len", last_len, exp_last);
        chk("frame_reads", reads, total);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   exp_und;
        int   rv_seen;
        bit   seen;

        tbl[0] = '{100, 2, 100, 4, 8};
        tbl[1] = '{0, 7, 100, 0, 0};
        tbl[2] = '{64, 1, 100, 1, 64};
        tbl[3] = '{1, 1, 100, 1, 1};
        tbl[4] = '{65, 1, 100, 2, 1};
        tbl[5] = '{30, 3, 100, 2, 26};
        tbl[6] = '{7, 100, 70, 11, 60};

        rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; hactive = '0; vactive = '0;
        req_ready = 1'b0; din = '0; din_valid = 1'b0; rd_en = 1'b0;
        m_pend = 0; m_old = 0; frame_no = 0; seq = 0; reads = 0; n_req = 0;
        last_len = 0; cyc = 0; coin = 0; m_rem = 0; cur_btag = 0;
        prev_hold = 1'b0; prev_fs = 1'b0; prev_len = '0;

        #7;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_len", req_len, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_in_data", in_data, 0);
        chk("rst_underrun", underrun_cnt, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // IDLE: no request may appear (model remaining is 0)
        repeat (10) cycle();

        for (int i = 0; i < 7; i++) begin
            en_pct = tbl[i].en_pct;
            frame_begin(tbl[i].h, tbl[i].v);
            finish_frame(tbl[i].exp_reqs, tbl[i].exp_last, 6000);
        end
        en_pct = 100;
        chk("coincident_beat_pop_accept_seen", coin > 0, 1);

        // Back-pressure: no reads, 2000-beat frame fills the buffer exactly
        rd_auto = 1'b0; rd_en = 1'b0; rdy_pct = 100; din_pct = 100;
        frame_begin(1000, 2);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (mq.size() == 1024 && m_pend == 0) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        chk("bp_filled", seen, 1);
        rv_seen = 0;
        repeat (20) begin
            if (req_valid) rv_seen++;
            cycle();
        end
        chk("bp_no_req_when_full", rv_seen, 0);
        chk("bp_n_req", n_req, 16);
        chk("bp_not_empty", fifo_empty, 0);
        rd_en = 1'b1;
        repeat (64) cycle();
        rd_en = 1'b0;
        chk("bp_n_req_after_pop", n_req, 16);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        chk("bp_rearm", seen, 1);
        rd_auto = 1'b1; rdy_pct = 70; din_pct = 80;
        finish_frame(32, 16, 10000);

        // Flush with 40 beats still in flight
        rd_auto = 1'b0; rd_en = 1'b0; rdy_pct = 100; lat = 60;
        frame_begin(40, 1);
        for (int i = 0; i < 20 && n_req == 0; i++) cycle();
        chk("fl_first_req", n_req, 1);
        repeat (3) cycle();
        lat = 3;
        frame_begin(50, 1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!fifo_empty) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        chk("fl_data_arrived", seen, 1);
        chk("fl_first_data", in_data, 24'((frame_no & 255) << 16));
        rd_auto = 1'b1; rdy_pct = 70;
        finish_frame(1, 50, 6000);

        // Underrun: five rd_en pulses while empty in RUN, no request granted
`ifdef VDMA_RD_UNDERRUN_CNT_EN
        exp_und = 5;
`else
        exp_und = 0;
`endif
        rd_auto = 1'b0; rd_en = 1'b0; rdy_pct = 0;
        frame_begin(200, 1);
        repeat (5) cycle();
        chk("und_cleared", underrun_cnt, 0);
        repeat (5) begin
            rd_en = 1'b1;
            cycle();
            rd_en = 1'b0;
            cycle();
        end
        chk("und_count", underrun_cnt, exp_und);
        chk("und_still_empty", fifo_empty, 1);
        rd_auto = 1'b1; rdy_pct = 70;
        finish_frame(4, 8, 6000);

        // Asynchronous reset mid-burst
        frame_begin(500, 1);
        repeat (100) cycle();
        @(negedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", req_valid, 0);
        chk("arst_req_len", req_len, 0);
        chk("arst_fifo_empty", fifo_empty, 1);
        chk("arst_in_data", in_data, 0);
        chk("arst_underrun", underrun_cnt, 0);
        flight.delete(); mq.delete();
        m_pend = 0; m_old = 0; m_rem = 0; reads = 0; n_req = 0; last_len = 0;
        prev_hold = 1'b0; prev_fs = 1'b0;
        din_valid = 1'b0; enable = 1'b1;
        @(posedge clock);
        #1;
        chk("arst_hold_req_valid", req_valid, 0);
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (20) begin
            if (req_valid) rv_seen++;
            cycle();
        end
        chk("arst_no_req_before_frame", rv_seen, 0);
        frame_begin(100, 2);
        finish_frame(4, 8, 6000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
